cache_controller: RTL and testbench

Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller. Serves read hits in the request cycle. Sequences the SRAM controller for read-miss line fills and write-through stores. Drives `ready` to freeze the pipeline while an SRAM transaction is in flight.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_if.sv | 28 ++
 rtl/cache_array.sv | 65 ++++++
 rtl/cache_controller.sv | 150 +++++++++++++++
 tb/tb_cache_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, FSM encoding and address decode for the two-way data cache.
package cache_pkg;

  localparam int MEM_BASE = 1024;
  localparam int NUM_SETS = 64;
  localparam int INDEX_W  = 6;
  localparam int TAG_W    = 10;
  localparam int LINE_W   = 64;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_MISS = 2'd1,
    ST_WRITE     = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               word_sel;
  } addr_fields_t;

  // Only bits [18:2] matter, so the base is subtracted on that slice alone.
  function automatic addr_fields_t decode_addr(input logic [31:0] address);
    logic [16:0] a;
    a = address[18:2] - 17'(MEM_BASE >> 2);
    return addr_fields_t'(a);
  endfunction

endpackage

// File: rtl/cache_if.sv
// MEM-stage and SRAM-controller signals of the cache; slave is the cache side.
interface cache_if;
  import cache_pkg::*;

  logic              wrEn;
  logic              rdEn;
  logic [31:0]       address;
  logic [31:0]       writeData;
  logic [31:0]       readData;
  logic              ready;
  logic              sramWrEn;
  logic              sramRdEn;
  logic [31:0]       sramAddress;
  logic [31:0]       sramWriteData;
  logic [LINE_W-1:0] sramReadData;
  logic              sramReady;

  modport master (
    output wrEn, rdEn, address, writeData, sramReadData, sramReady,
    input  readData, ready, sramWrEn, sramRdEn, sramAddress, sramWriteData
  );

  modport slave (
    input  wrEn, rdEn, address, writeData, sramReadData, sramReady,
    output readData, ready, sramWrEn, sramRdEn, sramAddress, sramWriteData
  );

endinterface

// File: rtl/cache_array.sv
// Valid/tag/data/LRU storage for 64 sets x 2 ways with combinational lookup.
module cache_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               word_sel,
  output logic               hit,
  output logic               hit_way,
  output logic [WORD_W-1:0]  word,
  output logic               victim,
  input  logic               fill_en,
  input  logic               fill_way,
  input  logic [LINE_W-1:0]  fill_line,
  input  logic               wr_word_en,
  input  logic               wr_way,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               touch_en,
  input  logic               touch_way
);

  logic [NUM_SETS-1:0] valid_q [2];
  logic [TAG_W-1:0]    tag_q   [2][NUM_SETS];
  logic [LINE_W-1:0]   data_q  [2][NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;

  logic                hit0;
  logic                hit1;
  logic [LINE_W-1:0]   line_sel;

  always_comb begin
    hit0     = valid_q[0][index] && (tag_q[0][index] == tag);
    hit1     = valid_q[1][index] && (tag_q[1][index] == tag);
    hit      = hit0 | hit1;
    hit_way  = hit1;
    line_sel = data_q[hit_way][index];
    word     = word_sel ? line_sel[63:32] : line_sel[31:0];
    victim   = lru_q[index];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      if (fill_en)  valid_q[fill_way][index] <= 1'b1;
      if (touch_en) lru_q[index] <= ~touch_way;
    end
  end

  // Tags and data need no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_way][index]  <= tag;
      data_q[fill_way][index] <= fill_line;
    end else if (wr_word_en) begin
      if (word_sel) data_q[wr_way][index][63:32] <= wr_data;
      else          data_q[wr_way][index][31:0]  <= wr_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
//
// state        | meaning
// ST_IDLE      | serve read hits, accept new requests
// ST_READ_MISS | line fill from SRAM in flight
// ST_WRITE     | write-through store in flight
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  cache_if.slave      bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
`endif
);

  state_t              state_q;
  state_t              state_d;
  addr_fields_t        fields;

  logic                lk_hit;
  logic                lk_hit_way;
  logic [WORD_W-1:0]   lk_word;
  logic                lk_victim;

  logic                fill_en;
  logic                wr_word_en;
  logic                touch_en;
  logic                touch_way;
  logic                ready;
  logic [WORD_W-1:0]   rd_data;
  logic                sram_rd;
  logic                sram_wr;

  assign fields = decode_addr(bus.address);

  cache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (fields.index),
    .tag        (fields.tag),
    .word_sel   (fields.word_sel),
    .hit        (lk_hit),
    .hit_way    (lk_hit_way),
    .word       (lk_word),
    .victim     (lk_victim),
    .fill_en    (fill_en),
    .fill_way   (lk_victim),
    .fill_line  (bus.sramReadData),
    .wr_word_en (wr_word_en),
    .wr_way     (lk_hit_way),
    .wr_data    (bus.writeData),
    .touch_en   (touch_en),
    .touch_way  (touch_way)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b1;
    rd_data    = '0;
    sram_rd    = 1'b0;
    sram_wr    = 1'b0;
    fill_en    = 1'b0;
    wr_word_en = 1'b0;
    touch_en   = 1'b0;
    touch_way  = lk_hit_way;
    case (state_q)
      ST_IDLE: begin
        if (bus.wrEn) begin
          ready   = 1'b0;
          state_d = ST_WRITE;
        end else if (bus.rdEn) begin
          if (lk_hit) begin
            rd_data  = lk_word;
            touch_en = 1'b1;
          end else begin
            ready   = 1'b0;
            state_d = ST_READ_MISS;
          end
        end
      end
      ST_READ_MISS: begin
        sram_rd = 1'b1;
        ready   = 1'b0;
        if (bus.sramReady) begin
          fill_en   = 1'b1;
          touch_en  = 1'b1;
          touch_way = lk_victim;
          ready     = 1'b1;
          rd_data   = fields.word_sel ? bus.sramReadData[63:32] : bus.sramReadData[31:0];
          state_d   = ST_IDLE;
        end
      end
      ST_WRITE: begin
        sram_wr = 1'b1;
        ready   = 1'b0;
        if (bus.sramReady) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
          if (lk_hit) begin
            wr_word_en = 1'b1;
            touch_en   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A reset edge abandons any transaction without touching the arrays.
    if (!rst) begin
      fill_en    = 1'b0;
      wr_word_en = 1'b0;
      touch_en   = 1'b0;
    end
  end

  assign bus.ready         = ready;
  assign bus.readData      = (ready && bus.rdEn) ? rd_data : '0;
  assign bus.sramRdEn      = sram_rd;
  assign bus.sramWrEn      = sram_wr;
  assign bus.sramAddress   = bus.address;
  assign bus.sramWriteData = bus.writeData;

`ifdef CACHE_STATS_EN
  logic hit_done;
  logic miss_done;

  assign hit_done  = (state_q == ST_IDLE) && !bus.wrEn && bus.rdEn && lk_hit;
  assign miss_done = (state_q == ST_READ_MISS) && bus.sramReady;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (hit_done && hitCount != 16'hFFFF)   hitCount  <= hitCount + 16'd1;
      if (miss_done && missCount != 16'hFFFF) missCount <= missCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed table-driven bench for cache_controller with a fixed-latency SRAM stand-in.
module tb_cache_controller;
  import cache_pkg::*;

  logic clk;
  logic rst;
  cache_if bus();

`ifdef CACHE_STATS_EN
  logic [15:0] hitCount;
  logic [15:0] missCount;
`endif

  cache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef CACHE_STATS_EN
    ,
    .hitCount  (hitCount),
    .missCount (missCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] line;
    logic        hit;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [63:0] line,
                              input logic hit, input logic [31:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.line = line; v.hit = hit; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction; misses and writes see sramReady five cycles after the enable rises.
  task automatic txn(input vec_t v);
    @(posedge clk); #1;
    bus.rdEn = v.rd; bus.wrEn = v.wr; bus.address = v.addr; bus.writeData = v.wdata;
    bus.sramReady = 1'b0;
    @(negedge clk);
    chk("sram_addr", bus.sramAddress, v.addr);
    chk("sram_wdata", bus.sramWriteData, v.wdata);
    if (v.rd && !v.wr && v.hit) begin
      chk("hit_ready", bus.ready, 1'b1);
      chk("hit_data", bus.readData, v.exp);
      chk("hit_no_sram", bus.sramRdEn, 1'b0);
    end else begin
      chk("req_ready", bus.ready, 1'b0);
      chk("req_no_sram", {bus.sramRdEn, bus.sramWrEn}, 2'b00);
      for (int cyc = 1; cyc <= 5; cyc++) begin
        @(posedge clk); #1;
        if (cyc == 5) begin
          bus.sramReady = 1'b1;
          bus.sramReadData = v.line;
        end
        @(negedge clk);
        if (v.wr) chk("wr_enables", {bus.sramWrEn, bus.sramRdEn}, 2'b10);
        else      chk("rd_enables", {bus.sramRdEn, bus.sramWrEn}, 2'b10);
        chk("busy_ready", bus.ready, (cyc == 5) ? 1'b1 : 1'b0);
        if (cyc == 5 && !v.wr) chk("fill_data", bus.readData, v.exp);
      end
    end
    @(posedge clk); #1;
    bus.rdEn = 1'b0; bus.wrEn = 1'b0; bus.sramReady = 1'b0;
    @(negedge clk);
    chk("idle_enables", {bus.sramRdEn, bus.sramWrEn}, 2'b00);
    chk("idle_ready", bus.ready, 1'b1);
  endtask

  initial begin
    bus.rdEn = 1'b0; bus.wrEn = 1'b0; bus.address = 32'd1024; bus.writeData = '0;
    bus.sramReadData = '0; bus.sramReady = 1'b0;
    rst = 1'b0;

    //           rd    wr    addr    wdata          line                    hit   exp
    vecs.push_back(mk(1'b1, 1'b0, 32'd1024, 32'h0, 64'h1111_2222_3333_4444, 1'b0, 32'h3333_4444));
    vecs.push_back(mk(1'b1, 1'b0, 32'd1028, 32'h0, 64'h0,                   1'b1, 32'h1111_2222));
    vecs.push_back(mk(1'b1, 1'b0, 32'd1536, 32'h0, 64'hBBBB_0001_BBBB_0000, 1'b0, 32'hBBBB_0000));
    vecs.push_back(mk(1'b1, 1'b0, 32'd1024, 32'h0, 64'h0,                   1'b1, 32'h3333_4444));
    vecs.push_back(mk(1'b1, 1'b0, 32'd2048, 32'h0, 64'hCCCC_0001_CCCC_0000, 1'b0, 32'hCCCC_0000));
    vecs.push_back(mk(1'b1, 1'b0, 32'd1024, 32'h0, 64'h0,                   1'b1, 32'h3333_4444));
    vecs.push_back(mk(1'b1, 1'b0, 32'd1536, 32'h0, 64'hBBBB_0001_BBBB_0000, 1'b0, 32'hBBBB_0000));
    vecs.push_back(mk(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 64'h0,           1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 32'd1028, 32'h0, 64'h0,                   1'b1, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b1, 1'b0, 32'd1024, 32'h0, 64'h0,                   1'b1, 32'h3333_4444));
    vecs.push_back(mk(1'b0, 1'b1, 32'd4096, 32'h1234_5678, 64'h0,           1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 32'd4096, 32'h0, 64'h9999_8888_7777_6666, 1'b0, 32'h7777_6666));
    vecs.push_back(mk(1'b1, 1'b0, 32'd4100, 32'h0, 64'h0,                   1'b1, 32'h9999_8888));
    vecs.push_back(mk(1'b1, 1'b0, 32'd1032, 32'h0, 64'h0000_00AA_0000_00BB, 1'b0, 32'h0000_00BB));
    vecs.push_back(mk(1'b1, 1'b0, 32'd1036, 32'h0, 64'h0,                   1'b1, 32'h0000_00AA));
    vecs.push_back(mk(1'b1, 1'b1, 32'd1040, 32'hCAFE_F00D, 64'h5555_6666_7777_8888, 1'b0, 32'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_rdata", bus.readData, 32'h0);
    chk("rst_enables", {bus.sramRdEn, bus.sramWrEn}, 2'b00);
`ifdef CACHE_STATS_EN
    chk("rst_hitcnt", hitCount, 16'h0);
    chk("rst_misscnt", missCount, 16'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) begin
      txn(vecs[i]);
      if (vecs[i].rd && !vecs[i].wr) begin
        if (vecs[i].hit) exp_hits++;
        else             exp_misses++;
      end
    end

`ifdef CACHE_STATS_EN
    chk("hit_count", hitCount, 16'(exp_hits));
    chk("miss_count", missCount, 16'(exp_misses));
`endif

    // Reset in the middle of a line fill.
    @(posedge clk); #1;
    bus.rdEn = 1'b1; bus.address = 32'd1040;
    @(negedge clk);
    chk("rm_start_ready", bus.ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; bus.rdEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rm_rst_enables", {bus.sramRdEn, bus.sramWrEn}, 2'b00);
    chk("rm_rst_ready", bus.ready, 1'b1);
    chk("rm_rst_rdata", bus.readData, 32'h0);
`ifdef CACHE_STATS_EN
    chk("rm_rst_hitcnt", hitCount, 16'h0);
    chk("rm_rst_misscnt", missCount, 16'h0);
`endif
    txn(mk(1'b1, 1'b0, 32'd1040, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 32'hCCCC_DDDD));
    txn(mk(1'b1, 1'b0, 32'd1024, 32'h0, 64'h0102_0304_0506_0708, 1'b0, 32'h0506_0708));
    txn(mk(1'b1, 1'b0, 32'd1028, 32'h0, 64'h0,                   1'b1, 32'h0102_0304));

`ifdef CACHE_STATS_EN
    // Back-to-back hits held for more than 2^16 cycles saturate the hit counter.
    @(posedge clk); #1;
    bus.rdEn = 1'b1; bus.address = 32'd1028;
    repeat (65540) @(posedge clk);
    #1;
    bus.rdEn = 1'b0;
    @(negedge clk);
    chk("hit_sat", hitCount, 16'hFFFF);
    chk("miss_after_sat", missCount, 16'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
